// File: rtl/pipe_reg_file.sv
// Parametrised register file: two combinational read ports, one write port, per-register busy scoreboard.
// Latency: reads are zero-cycle combinational; writes and busy updates take effect at the next rising Clk edge.
// Backpressure: none; the scoreboard publishes busy bits and AnyBusy so that hazard logic upstream can stall.
//
// Optional macro REGFILE_BYPASS_EN: when defined, same-cycle write data is forwarded
// to a read port whose index matches the write, and that port's busy bit shows the
// post-edge value. When undefined, reads always return the stored state.

module pipe_reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [DATA_W-1:0] RdDataA,
    output logic [DATA_W-1:0] RdDataB,
    output logic              RdBusyA,
    output logic              RdBusyB,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              ReserveEn,
    input  logic [ADDR_W-1:0] ReserveAddr,
    input  logic              Flush,
    output logic              AnyBusy
);

    // Register 0 is hardwired to zero, unwritable and never busy when this is set.
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    // NUM_REGS is 2**ADDR_W, so every index addresses a real register.
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // Qualified write and reserve requests, with the zero register filtered out.
    logic                wr_ok;
    logic                res_ok;
    logic [NUM_REGS-1:0] wr_dec;
    logic [NUM_REGS-1:0] res_dec;

    // Per-port read results, before driving the output ports.
    logic [DATA_W-1:0]   data_a;
    logic [DATA_W-1:0]   data_b;
    logic                bsy_a;
    logic                bsy_b;
    logic                zero_a;
    logic                zero_b;

    // Qualify write and reserve; Flush suppresses any reservation in the same cycle.
    always_comb begin
        wr_ok  = WE && !(HAS_ZERO && (WrAddr == '0));
        res_ok = ReserveEn && !Flush && !(HAS_ZERO && (ReserveAddr == '0));
    end

    // One-hot decode of the write and reserve targets.
    always_comb begin
        wr_dec              = '0;
        res_dec             = '0;
        wr_dec[WrAddr]      = wr_ok;
        res_dec[ReserveAddr] = res_ok;
    end

    // Data storage: async clear on reset, single write per edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[WrAddr] <= WrData;
        end
    end

    // Busy scoreboard: flush clears everything; otherwise a write releases its
    // destination and a reserve sets its target, the reserve winning on a shared
    // index so back-to-back producers of one register keep it pending.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy <= '0;
        end else if (Flush) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wr_dec) | res_dec;
        end
    end

    // Read port A: stored value, optionally forwarded from the same-cycle write.
    always_comb begin
        zero_a = HAS_ZERO && (RdAddrA == '0);
        data_a = regs[RdAddrA];
        bsy_a  = busy[RdAddrA];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (WrAddr == RdAddrA)) begin
            data_a = WrData;
            bsy_a  = res_ok && (ReserveAddr == RdAddrA);
        end
`endif
        if (Reset || zero_a) begin
            data_a = '0;
            bsy_a  = 1'b0;
        end
    end

    // Read port B: identical structure to port A.
    always_comb begin
        zero_b = HAS_ZERO && (RdAddrB == '0);
        data_b = regs[RdAddrB];
        bsy_b  = busy[RdAddrB];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (WrAddr == RdAddrB)) begin
            data_b = WrData;
            bsy_b  = res_ok && (ReserveAddr == RdAddrB);
        end
`endif
        if (Reset || zero_b) begin
            data_b = '0;
            bsy_b  = 1'b0;
        end
    end

    // Drive outputs; AnyBusy reflects stored reservations only.
    always_comb begin
        RdDataA = data_a;
        RdDataB = data_b;
        RdBusyA = bsy_a;
        RdBusyB = bsy_b;
        AnyBusy = !Reset && (|busy);
    end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed bench for pipe_reg_file with a queue-based expected-value scoreboard.
// Each step pushes its expectations when driving stimulus and pops them when sampling.
// Outputs are sampled 1 time unit after the rising edge or after a combinational input change.

module tb_pipe_reg_file;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          Clk;
    logic          Reset;
    logic [AW-1:0] RdAddrA;
    logic [AW-1:0] RdAddrB;
    logic [DW-1:0] RdDataA;
    logic [DW-1:0] RdDataB;
    logic          RdBusyA;
    logic          RdBusyB;
    logic          WE;
    logic [AW-1:0] WrAddr;
    logic [DW-1:0] WrData;
    logic          ReserveEn;
    logic [AW-1:0] ReserveAddr;
    logic          Flush;
    logic          AnyBusy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    pipe_reg_file #(
        .DATA_W  (DW),
        .NUM_REGS(NR),
        .ADDR_W  (AW),
        .ZERO_REG(1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .RdAddrA    (RdAddrA),
        .RdAddrB    (RdAddrB),
        .RdDataA    (RdDataA),
        .RdDataB    (RdDataB),
        .RdBusyA    (RdBusyA),
        .RdBusyB    (RdBusyB),
        .WE         (WE),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .ReserveEn  (ReserveEn),
        .ReserveAddr(ReserveAddr),
        .Flush      (Flush),
        .AnyBusy    (AnyBusy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
        RdAddrA = a;
        RdAddrB = b;
        #1;
    endtask

    task automatic idle();
        WE        = 1'b0;
        ReserveEn = 1'b0;
        Flush     = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; RdAddrA = '0; RdAddrB = '0; WE = 1'b0; WrAddr = '0;
        WrData = '0; ReserveEn = 1'b0; ReserveAddr = '0; Flush = 1'b0;

        // Reset state
        rd(5'd5, 5'd7);
        expect_val("rst_data_a", 32'h0); check(RdDataA);
        expect_val("rst_busy_b", 32'h0); check(RdBusyB);
        expect_val("rst_anybusy", 32'h0); check(AnyBusy);
        tick();
        Reset = 1'b0;
        #1;

        // Test 1: basic write, pre-edge visibility depends on forwarding
        WE = 1'b1; WrAddr = 5'd5; WrData = 32'hDEADBEEF; rd(5'd5, 5'd6);
`ifdef REGFILE_BYPASS_EN
        expect_val("t1_pre_edge", 32'hDEADBEEF);
`else
        expect_val("t1_pre_edge", 32'h0);
`endif
        check(RdDataA);
        tick(); idle();
        rd(5'd5, 5'd6);
        expect_val("t1_reg5", 32'hDEADBEEF); check(RdDataA);
        for (int i = 0; i < NR; i++) begin
            if (i != 5) begin
                rd(AW'(i), AW'(i));
                expect_val($sformatf("t1_zero_r%0d", i), 32'h0);
                check(RdDataB);
            end
        end

        // Test 2: register 0 ignores writes and reservations
        WE = 1'b1; WrAddr = 5'd0; WrData = 32'h12345678;
        ReserveEn = 1'b1; ReserveAddr = 5'd0; rd(5'd0, 5'd0);
        expect_val("t2_pre_data0", 32'h0); check(RdDataA);
        tick(); idle(); #1;
        expect_val("t2_data0", 32'h0); check(RdDataA);
        expect_val("t2_busy0", 32'h0); check(RdBusyA);
        expect_val("t2_anybusy", 32'h0); check(AnyBusy);

        // Test 3: reserve then release by writeback
        ReserveEn = 1'b1; ReserveAddr = 5'd7;
        tick(); idle(); rd(5'd0, 5'd7);
        expect_val("t3_busy7", 32'h1); check(RdBusyB);
        expect_val("t3_anybusy", 32'h1); check(AnyBusy);
        WE = 1'b1; WrAddr = 5'd7; WrData = 32'hA5; #1;
`ifdef REGFILE_BYPASS_EN
        expect_val("t3_pre_data7", 32'hA5);
        expect_val("t3_pre_busy7", 32'h0);
`else
        expect_val("t3_pre_data7", 32'h0);
        expect_val("t3_pre_busy7", 32'h1);
`endif
        check(RdDataB); check(RdBusyB);
        tick(); idle(); #1;
        expect_val("t3_busy7_rel", 32'h0); check(RdBusyB);
        expect_val("t3_data7", 32'hA5); check(RdDataB);
        expect_val("t3_anybusy_rel", 32'h0); check(AnyBusy);

        // Test 4: same-register write and reserve: reserve wins, data updates
        WE = 1'b1; WrAddr = 5'd9; WrData = 32'h55;
        ReserveEn = 1'b1; ReserveAddr = 5'd9; rd(5'd9, 5'd0);
        tick(); idle(); #1;
        expect_val("t4_data9", 32'h55); check(RdDataA);
        expect_val("t4_busy9", 32'h1); check(RdBusyA);

        // Write and reserve on different registers both take effect
        WE = 1'b1; WrAddr = 5'd10; WrData = 32'h10;
        ReserveEn = 1'b1; ReserveAddr = 5'd11;
        tick(); idle(); rd(5'd10, 5'd11);
        expect_val("t4_data10", 32'h10); check(RdDataA);
        expect_val("t4_busy10", 32'h0); check(RdBusyA);
        expect_val("t4_busy11", 32'h1); check(RdBusyB);

        // Test 5: several reservations, then flush with a simultaneous write
        ReserveEn = 1'b1; ReserveAddr = 5'd3; tick();
        ReserveAddr = 5'd4; tick();
        ReserveAddr = 5'd31; tick(); idle();
        rd(5'd3, 5'd31);
        expect_val("t5_busy3", 32'h1); check(RdBusyA);
        expect_val("t5_busy31", 32'h1); check(RdBusyB);
        rd(5'd4, 5'd9);
        expect_val("t5_busy4", 32'h1); check(RdBusyA);
        expect_val("t5_anybusy", 32'h1); check(AnyBusy);
        Flush = 1'b1; WE = 1'b1; WrAddr = 5'd4; WrData = 32'h77;
        ReserveEn = 1'b1; ReserveAddr = 5'd12;
        tick(); idle();
        for (int i = 0; i < NR; i++) begin
            rd(AW'(i), AW'(i));
            expect_val($sformatf("t5_flushed_busy%0d", i), 32'h0);
            check(RdBusyA);
        end
        expect_val("t5_anybusy_flushed", 32'h0); check(AnyBusy);
        rd(5'd4, 5'd12);
        expect_val("t5_data4", 32'h77); check(RdDataA);

        // WE low leaves state alone regardless of WrAddr/WrData
        WrAddr = 5'd4; WrData = 32'hFFFF_FFFF;
        tick(); #1;
        expect_val("t5_we_low_data4", 32'h77); check(RdDataA);

        // Test 6: forwarding visibility before the edge
        WE = 1'b1; WrAddr = 5'd2; WrData = 32'h11;
        tick(); idle();
        WE = 1'b1; WrAddr = 5'd2; WrData = 32'h22; rd(5'd2, 5'd2);
`ifdef REGFILE_BYPASS_EN
        expect_val("t6_pre_edge", 32'h22);
`else
        expect_val("t6_pre_edge", 32'h11);
`endif
        check(RdDataA);
        tick(); idle(); #1;
        expect_val("t6_post_edge", 32'h22); check(RdDataA);

        // Mid-cycle asynchronous reset clears everything immediately
        ReserveEn = 1'b1; ReserveAddr = 5'd5;
        tick(); idle(); rd(5'd2, 5'd5);
        expect_val("t6_busy5_before_rst", 32'h1); check(RdBusyB);
        WE = 1'b1; WrAddr = 5'd2; WrData = 32'h33;
        #1;
        Reset = 1'b1;
        #1;
        expect_val("t6_rst_data_a", 32'h0); check(RdDataA);
        expect_val("t6_rst_data_b", 32'h0); check(RdDataB);
        expect_val("t6_rst_busy_b", 32'h0); check(RdBusyB);
        expect_val("t6_rst_anybusy", 32'h0); check(AnyBusy);
        WE = 1'b0;
        #1;
        Reset = 1'b0;
        rd(5'd10, 5'd5);
        expect_val("t6_after_rst_data10", 32'h0); check(RdDataA);
        expect_val("t6_after_rst_busy5", 32'h0); check(RdBusyB);
        WE = 1'b1; WrAddr = 5'd6; WrData = 32'h66;
        tick(); idle(); rd(5'd6, 5'd5);
        expect_val("t6_first_edge_write", 32'h66); check(RdDataA);

        // Every pushed expectation must have been consumed
        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
